// File: rtl/rr_source_arbiter.sv
// Round-robin arbiter for 8 sources driving the select of a downstream 8:1 mux.
// A grant is held through valid/ready handshakes, for up to BURST_LEN words, then priority rotates.
module rr_source_arbiter #(
  parameter int BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       out_ready,
  output logic [2:0] grant_sel,
  output logic [7:0] grant_onehot,
  output logic       out_valid,
  output logic [7:0] ack,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [7:0] bcnt, bcnt_nxt;
  logic [2:0] sel_nxt;
  logic [7:0] oh_nxt;
  logic       vld_nxt;
  logic       hs;
  logic       burst_more;
  logic [3:0] pick;
  logic [3:0] repick;

  // Returns {found, index} of the first set bit scanning p, p+1, ... p+7 (mod 8).
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign hs         = out_valid & out_ready;
  assign burst_more = req[grant_sel] && (bcnt < 8'(BURST_LEN));
  assign pick       = rr_pick(req, ptr);
  // The finishing source is masked so it cannot win the immediate re-grant.
  assign repick     = rr_pick(req & ~(8'b1 << grant_sel), grant_sel + 3'd1);
  assign ack        = {8{hs}} & grant_onehot;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    bcnt_nxt  = bcnt;
    sel_nxt   = grant_sel;
    oh_nxt    = grant_onehot;
    vld_nxt   = out_valid;
    case (state)
      IDLE: begin
        if (pick[3]) begin
          state_nxt = GRANT;
          sel_nxt   = pick[2:0];
          oh_nxt    = 8'b1 << pick[2:0];
          vld_nxt   = 1'b1;
          bcnt_nxt  = 8'd1;
        end
      end
      GRANT: begin
        if (hs) begin
          if (burst_more) begin
            bcnt_nxt = bcnt + 8'd1;
          end else begin
            ptr_nxt = grant_sel + 3'd1;
            if (repick[3]) begin
              sel_nxt  = repick[2:0];
              oh_nxt   = 8'b1 << repick[2:0];
              bcnt_nxt = 8'd1;
            end else begin
              state_nxt = IDLE;
              oh_nxt    = 8'h00;
              vld_nxt   = 1'b0;
              bcnt_nxt  = 8'd0;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= 3'd0;
      bcnt         <= 8'd0;
      grant_sel    <= 3'd0;
      grant_onehot <= 8'h00;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      bcnt         <= bcnt_nxt;
      grant_sel    <= sel_nxt;
      grant_onehot <= oh_nxt;
      out_valid    <= vld_nxt;
      busy         <= (state_nxt == GRANT);
    end
  end

endmodule
